// File: rtl/regression_sample_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regression_sample_feeder_if                                     |
// | Brief    : Host write port and controller handshake for the sample feeder. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface regression_sample_feeder_if #(
  parameter int DW = 20
) ();
  logic          wr_en;
  logic [DW-1:0] wr_x;
  logic [DW-1:0] wr_y;
  logic          load_done;
  logic          coeff_ready;
  logic          coeff_done;
  logic          en;
  logic          cout;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
`ifdef FEEDER_REPLAY_EN
  logic          replay;

  modport master (
    output wr_en, wr_x, wr_y, load_done, coeff_ready, coeff_done, replay,
    input  en, cout, x_out, y_out
  );
  modport slave (
    input  wr_en, wr_x, wr_y, load_done, coeff_ready, coeff_done, replay,
    output en, cout, x_out, y_out
  );
`else
  modport master (
    output wr_en, wr_x, wr_y, load_done, coeff_ready, coeff_done,
    input  en, cout, x_out, y_out
  );
  modport slave (
    input  wr_en, wr_x, wr_y, load_done, coeff_ready, coeff_done,
    output en, cout, x_out, y_out
  );
`endif
endinterface
`default_nettype wire

// File: rtl/regression_sample_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regression_sample_feeder                                        |
// | Brief    : Buffers a host batch of (x,y) samples and streams it to the     |
// |            coefficient controller. Optional macro FEEDER_REPLAY_EN.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regression_sample_feeder #(
  parameter int DW    = 20,
  parameter int DEPTH = 150,
  parameter int AW    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  regression_sample_feeder_if.slave     bus,
  output logic [AW-1:0]                 count,
  output logic                          full,
  output logic                          ovf,
  output logic                          busy,
  output logic                          batch_done
);

  localparam logic [AW-1:0] c_depth = AW'(DEPTH);
  localparam logic [AW-1:0] c_one   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_START  = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [DW-1:0]   r_x_out;
  logic [DW-1:0]   r_y_out;
  logic            r_ovf;
  logic            r_en_phase;
  logic            r_batch_done;
  logic [2*DW-1:0] r_mem [DEPTH];

  logic            w_full;
  logic            w_cout;
  logic            w_en;
  logic            w_busy;
  logic            w_mem_wr;
  logic            w_drop;
  logic            w_accept;
  logic            w_replay;
  logic [AW-1:0]   w_wr_addr;

  assign w_full = (r_count == c_depth);

`ifdef FEEDER_REPLAY_EN
  assign w_replay = bus.replay && (r_count != '0);
`else
  assign w_replay = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_en      = 1'b0;
    w_busy    = 1'b1;
    w_cout    = 1'b0;
    w_mem_wr  = 1'b0;
    w_drop    = 1'b0;
    w_accept  = 1'b0;
    w_wr_addr = r_count;
    case (r_state)
      S_IDLE: begin
        w_busy    = 1'b0;
        w_wr_addr = '0;
        if (bus.wr_en) begin
          w_mem_wr = 1'b1;
          w_next   = S_LOAD;
        end else if (w_replay) begin
          w_next = S_ARM;
        end
      end
      S_LOAD: begin
        w_busy = 1'b0;
        // A write coinciding with load_done still lands in the batch.
        if (bus.wr_en) begin
          if (w_full) w_drop   = 1'b1;
          else        w_mem_wr = 1'b1;
        end
        if (bus.load_done) w_next = S_ARM;
      end
      S_ARM: begin
        if (bus.coeff_done) w_next = S_START;
      end
      S_START: begin
        w_en = 1'b1;
        if (r_en_phase) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_cout = (r_rd_ptr == r_count);
        if (bus.coeff_ready) begin
          if (w_cout) w_next   = S_DRAIN;
          else        w_accept = 1'b1;
        end
      end
      S_DRAIN: begin
        w_cout = (r_rd_ptr == r_count);
        if (bus.coeff_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sample store has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[w_wr_addr] <= {bus.wr_x, bus.wr_y};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_ovf        <= 1'b0;
      r_en_phase   <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      r_en_phase   <= (r_state == S_START) && !r_en_phase;

      if (r_state == S_IDLE && bus.wr_en) r_count <= c_one;
      else if (w_mem_wr)                  r_count <= r_count + c_one;

      if (w_drop) r_ovf <= 1'b1;

      if (r_state == S_ARM)  r_rd_ptr <= '0;
      else if (w_accept)     r_rd_ptr <= r_rd_ptr + c_one;

      if (w_accept) {r_x_out, r_y_out} <= r_mem[r_rd_ptr];

      if (r_state == S_DRAIN && bus.coeff_done) begin
        r_batch_done <= 1'b1;
        r_ovf        <= 1'b0;
`ifndef FEEDER_REPLAY_EN
        r_count      <= '0;
`endif
      end
    end
  end

  assign bus.en     = w_en;
  assign bus.cout   = w_cout;
  assign bus.x_out  = r_x_out;
  assign bus.y_out  = r_y_out;
  assign count      = r_count;
  assign full       = w_full;
  assign ovf        = r_ovf;
  assign busy       = w_busy;
  assign batch_done = r_batch_done;

endmodule
`default_nettype wire

// File: tb/tb_regression_sample_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regression_sample_feeder                                     |
// | Brief    : Directed self-checking bench for regression_sample_feeder.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_regression_sample_feeder;
  localparam int DW    = 20;
  localparam int DEPTH = 150;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] count;
  logic          full;
  logic          ovf;
  logic          busy;
  logic          batch_done;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  regression_sample_feeder_if #(.DW(DW)) bus ();

  regression_sample_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .ovf        (ovf),
    .busy       (busy),
    .batch_done (batch_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.wr_en = 1'b1;
    bus.wr_x  = x;
    bus.wr_y  = y;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en       = 1'b0;
    bus.wr_x        = '0;
    bus.wr_y        = '0;
    bus.load_done   = 1'b0;
    bus.coeff_ready = 1'b0;
    bus.coeff_done  = 1'b0;
`ifdef FEEDER_REPLAY_EN
    bus.replay      = 1'b0;
`endif
    tick();
    tick();
    chk("rst_en", bus.en, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_x", bus.x_out, 0);
    chk("rst_y", bus.y_out, 0);
    chk("rst_count", count, 0);

    // load_done with empty batch and stray coeff_ready are ignored in IDLE
    rst = 1'b1;
    bus.coeff_done  = 1'b1;
    bus.load_done   = 1'b1;
    bus.coeff_ready = 1'b1;
    tick();
    bus.load_done   = 1'b0;
    bus.coeff_ready = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_en", bus.en, 0);
    chk("idle_x", bus.x_out, 0);
    chk("idle_count", count, 0);

    // three-sample run
    wr(20'd1, 20'd2);
    wr(20'd3, 20'd4);
    wr(20'd5, 20'd6);
    chk("load_count", count, 3);
    chk("load_busy", busy, 0);
    chk("load_full", full, 0);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("arm_en", bus.en, 0);
    chk("arm_busy", busy, 1);
    tick();
    chk("start_en_c2", bus.en, 1);
    tick();
    chk("start_en_c3", bus.en, 1);
    tick();
    chk("stream_en", bus.en, 0);
    chk("stream_cout0", bus.cout, 0);
    bus.coeff_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("req_cout", bus.cout, 0);
      tick();
      chk("req_x", bus.x_out, 2 * i + 1);
      chk("req_y", bus.y_out, 2 * i + 2);
    end
    chk("end_cout", bus.cout, 1);
    bus.coeff_done = 1'b0;
    tick();
    bus.coeff_ready = 1'b0;
    chk("drain_x", bus.x_out, 5);
    chk("drain_y", bus.y_out, 6);
    chk("drain_busy", busy, 1);
    chk("drain_bd", batch_done, 0);
    tick();
    chk("drain_wait_bd", batch_done, 0);
    bus.coeff_done = 1'b1;
    tick();
    chk("done_bd", batch_done, 1);
    chk("done_busy", busy, 0);
`ifdef FEEDER_REPLAY_EN
    chk("done_count", count, 3);
`else
    chk("done_count", count, 0);
`endif
    tick();
    chk("done_bd_pulse", batch_done, 0);

`ifdef FEEDER_REPLAY_EN
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    chk("replay_busy", busy, 1);
    tick();
    tick();
    tick();
    bus.coeff_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("replay_x", bus.x_out, 2 * i + 1);
      chk("replay_y", bus.y_out, 2 * i + 2);
    end
    chk("replay_cout", bus.cout, 1);
    tick();
    bus.coeff_ready = 1'b0;
    tick();
    chk("replay_bd", batch_done, 1);
    chk("replay_count", count, 3);
`endif

    // start held off by coeff_done, writes outside LOAD ignored
    wr(20'd7, 20'd8);
    chk("hold_count", count, 1);
    bus.coeff_done = 1'b0;
    bus.load_done  = 1'b1;
    tick();
    bus.load_done  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_en", bus.en, 0);
      if (i == 2) bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
    end
    chk("hold_wr_count", count, 1);
    chk("hold_wr_ovf", ovf, 0);
    bus.coeff_done = 1'b1;
    tick();
    chk("hold_en_c1", bus.en, 1);
    tick();
    chk("hold_en_c2", bus.en, 1);
    tick();
    chk("hold_en_off", bus.en, 0);
    bus.coeff_ready = 1'b1;
    tick();
    bus.coeff_ready = 1'b0;
    chk("hold_x", bus.x_out, 7);
    chk("hold_y", bus.y_out, 8);

    // reset during STREAM
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_en", bus.en, 0);
    chk("midrst_cout", bus.cout, 0);
    chk("midrst_x", bus.x_out, 0);
    chk("midrst_y", bus.y_out, 0);
    chk("midrst_count", count, 0);

    // overflow: 151 writes into a 150-deep buffer
    bus.wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_x = 20'(i + 100);
      bus.wr_y = 20'(i + 500);
      tick();
    end
    chk("ovf_full", full, 1);
    chk("ovf_count150", count, 150);
    chk("ovf_pre", ovf, 0);
    bus.wr_x = 20'hFFFFF;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 150);
    chk("ovf_full2", full, 1);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    tick();
    tick();
    tick();
    bus.coeff_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("ovf_last_x", bus.x_out, 249);
    chk("ovf_last_y", bus.y_out, 649);
    chk("ovf_last_cout", bus.cout, 1);
    tick();
    bus.coeff_ready = 1'b0;
    chk("ovf_keep_x", bus.x_out, 249);
    tick();
    chk("ovf_bd", batch_done, 1);
    chk("ovf_cleared", ovf, 0);
`ifndef FEEDER_REPLAY_EN
    chk("ovf_count_clr", count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regression_sample_feeder.md
# regression_sample_feeder

Sample source for the coefficient-calculation controller and datapath. Buffers a batch of (x, y) samples written by the host, then drives the controller's start/ready protocol from the producer side. It raises `en` to launch a run, answers each `coeff_ready` request with the next sample pair and a `cout` end-of-data flag, and waits for `coeff_done` before accepting the next batch.

## Interface
- `DW`, 20: width of each x and y sample (two's complement).
- `DEPTH`, 150: maximum samples per batch.
- `AW`, 8: pointer/count width; must satisfy 2^AW > DEPTH.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `wr_en`  in  1  host write strobe; one sample per cycle.
- `wr_x`, `wr_y`  in  DW  host sample pair.
- `load_done`  in  1  host pulse; closes the batch.
- `coeff_ready`  in  1  controller request for the next sample; a one-cycle pulse.
- `coeff_done`  in  1  controller idle indication; level.
- `en`  out  1  start to the controller.
- `cout`  out  1  end of data; high when no unconsumed samples remain.
- `x_out`, `y_out`  out  DW  current sample pair presented to the datapath.
- `count`  out  AW  number of samples in the batch.
- `full`  out  1  `count == DEPTH`.
- `ovf`  out  1  sticky: a write was dropped because the buffer was full.
- `busy`  out  1  high in any state other than IDLE or LOAD.
- `batch_done`  out  1  one-cycle pulse when a run completes.

## Operation
- FSM states: IDLE, LOAD, ARM, START, STREAM, DRAIN.
- **IDLE**:
  - `wr_en` stores the sample at `mem[0]`, sets `count`=1 and goes to LOAD.
  - `load_done` with `count`=0 is ignored.
- **LOAD**:
  - Each `wr_en` with `!full` stores at `mem[count]` and increments `count`.
  - `wr_en` with `full` drops the sample and sets `ovf`.
  - `load_done` goes to ARM. If `wr_en` and `load_done` arrive in the same cycle, the write is included first.
- **ARM**:
  - Clears `rd_ptr` to 0.
  - Waits for `coeff_done`=1 (controller idle), then goes to START.
- **START**:
  - `en`=1 for exactly 2 cycles, then `en`=0 and the FSM enters STREAM.
  - The controller advances only after `en` falls.
- **STREAM**:
  - `cout` = (`rd_ptr == count`), a combinational compare of registered values. It is valid in the same cycle as `coeff_ready`.
  - On `coeff_ready` with `!cout`: the next edge loads `x_out`/`y_out` from `mem[rd_ptr]` and increments `rd_ptr`.
  - Outputs are held stable until the next accepted request.
  - On `coeff_ready` with `cout`: no data change; go to DRAIN.
- **DRAIN**:
  - Waits for `coeff_done`=1, then pulses `batch_done` for one cycle.
  - Returns to IDLE with `count`=0 and `ovf` cleared.
- `wr_en`/`load_done` outside IDLE and LOAD are ignored; they do not set `ovf`.
- `coeff_ready` outside STREAM is ignored.
- Arithmetic: `rd_ptr` and `count` are unsigned AW-bit values and never exceed DEPTH. Sample data passes through unmodified.

## Timing
- Reset (`rst`=0 at an edge): state IDLE. `en`, `cout`, `busy`, `batch_done`, `full`, `ovf` = 0; `x_out`, `y_out`, `count`, `rd_ptr` = 0. Memory contents are not cleared.
- Reset mid-run aborts immediately; the next cycle is IDLE with the values above.
- Latency, `load_done` to first `en`: 1 cycle (ARM) when `coeff_done`=1, plus however long `coeff_done` stays low.
- Latency, `coeff_ready` to new `x_out`/`y_out`: 1 cycle (registered).
- `cout` changes only on an `rd_ptr` update, i.e. the cycle after the accepted request.
- Back-to-back `coeff_ready` pulses on consecutive cycles are each accepted.
- The memory read is a synchronous-read array, inferable as block RAM.

## Configuration
- `FEEDER_REPLAY_EN` defined:
  - Adds input `replay` (1 bit).
  - A `replay` pulse in IDLE, with a retained batch (`count_saved` > 0), goes to ARM and re-streams the same data without a reload.
  - DRAIN returns to IDLE keeping `count`; `count` resets only on the first `wr_en` of a new batch.
- `FEEDER_REPLAY_EN` not defined:
  - No `replay` port.
  - DRAIN always clears `count`.

## Test plan
- Reset with `rst`=0 during STREAM -> next cycle: IDLE, all outputs 0, `count`=0.
- Load 3 samples (1,2), (3,4), (5,6), then `load_done` with `coeff_done`=1 -> `en` high for cycles 2–3 after `load_done`. Three `coeff_ready` pulses return those pairs in order with `cout`=0 at each request. A fourth request sees `cout`=1. `coeff_done`=1 then gives a single `batch_done` pulse.
- Write 151 samples with DEPTH=150 -> `full`=1 after the 150th, the 151st is dropped, `ovf`=1, `count`=150.
- `load_done` while `coeff_done`=0 for 5 cycles -> `en` stays 0 until `coeff_done` rises, then is high for exactly 2 cycles.
- `load_done` with `count`=0, plus `coeff_ready` while IDLE -> stays IDLE, `en`=0, `x_out` unchanged.
- With `FEEDER_REPLAY_EN`: complete a 2-sample run, then pulse `replay` -> same 2 pairs streamed again, `count` still 2.
